// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer: counts Tick pulses from a loaded value to zero
// and flags expiry with a one-cycle Tz pulse; one-shot or auto-reload operation.
module cnt_down_timer #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Pwr_off,
  input  logic         Tick,
  input  logic         Load,
  input  logic [W-1:0] Load_val,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Auto_reload,
  output logic         Load_ack,
  output logic         Load_err,
  output logic         Tz,
  output logic         Busy,
  output logic [W-1:0] Vout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};

  state_t         state_r;
  logic [W-1:0]   cnt_r;
  logic [W-1:0]   reload_r;
  logic           armed_r;
  logic           arst_n_s;
  logic [W-1:0]   start_cnt_s;

  // Power-off behaves exactly like reset, so both fold into one async clear.
  assign arst_n_s = Rst_n & ~Pwr_off;

  // A restart from DONE re-arms from the reload value; from IDLE it resumes the held count.
  assign start_cnt_s = (state_r == DONE) ? reload_r : cnt_r;

  // Timer FSM, counter and all registered outputs.
  always_ff @(posedge Clk or negedge arst_n_s) begin
    if (!arst_n_s) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO_C;
      reload_r <= ZERO_C;
      armed_r  <= 1'b0;
      Load_ack <= 1'b0;
      Load_err <= 1'b0;
      Tz       <= 1'b0;
      Busy     <= 1'b0;
      Vout     <= ZERO_C;
    end else begin
      Load_ack <= 1'b0;
      Load_err <= 1'b0;
      Tz       <= 1'b0;
      Vout     <= cnt_r;
      case (state_r)
        IDLE, DONE: begin
          Busy <= 1'b0;
          if (Load) begin
            cnt_r    <= Load_val;
            reload_r <= Load_val;
            armed_r  <= 1'b1;
            Load_ack <= 1'b1;
            state_r  <= IDLE;
          end else if (Start && armed_r) begin
            // Start is ignored after reset until a value has been loaded.
            cnt_r <= start_cnt_s;
            if (start_cnt_s != ZERO_C) begin
              state_r <= RUN;
              Busy    <= 1'b1;
            end else begin
              state_r <= DONE;
              Tz      <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          Busy     <= 1'b1;
          Load_err <= Load;
          if (Stop) begin
            state_r <= IDLE;
            Busy    <= 1'b0;
          end else if (Tick) begin
            if (cnt_r == ONE_C) begin
              Tz <= 1'b1;
              if (Auto_reload && (reload_r != ZERO_C)) begin
                cnt_r <= reload_r;
              end else begin
                cnt_r   <= ZERO_C;
                state_r <= DONE;
                Busy    <= 1'b0;
              end
            end else if (cnt_r != ZERO_C) begin
              cnt_r <= cnt_r - ONE_C;
            end else begin
              cnt_r <= ZERO_C;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= ZERO_C;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed bench for cnt_down_timer; expected values are hand-computed per step.
module tb_cnt_down_timer;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Pwr_off;
  logic         Tick;
  logic         Load;
  logic [W-1:0] Load_val;
  logic         Start;
  logic         Stop;
  logic         Auto_reload;
  logic         Load_ack;
  logic         Load_err;
  logic         Tz;
  logic         Busy;
  logic [W-1:0] Vout;

  int n_vec = 0;
  int n_err = 0;

  cnt_down_timer #(.W(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Pwr_off(Pwr_off), .Tick(Tick), .Load(Load),
    .Load_val(Load_val), .Start(Start), .Stop(Stop), .Auto_reload(Auto_reload),
    .Load_ack(Load_ack), .Load_err(Load_err), .Tz(Tz), .Busy(Busy), .Vout(Vout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic ld, input logic [W-1:0] lv, input logic st,
                     input logic sp, input logic tk);
    Load = ld; Load_val = lv; Start = st; Stop = sp; Tick = tk;
  endtask

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  logic [W-1:0] ar_vout [8] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd4, 16'd3, 16'd2, 16'd1};
  logic         ar_tz   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    Rst_n = 1'b0; Pwr_off = 1'b0; Auto_reload = 1'b0;
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    chk("rst_busy", Busy, 1'b0);
    chk("rst_tz", Tz, 1'b0);
    chk("rst_vout", Vout, 16'd0);
    chk("rst_ack", Load_ack, 1'b0);
    Rst_n = 1'b1;

    // 1: one-shot, load 3
    drv(1'b1, 16'd3, 1'b0, 1'b0, 1'b0); cyc();
    chk("t1_ack", Load_ack, 1'b1);
    chk("t1_busy_idle", Busy, 1'b0);
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b1); cyc();
    chk("t1_ack_pulse", Load_ack, 1'b0);
    chk("t1_busy_run", Busy, 1'b1);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc();
    chk("t1_vout3", Vout, 16'd3);
    cyc();
    chk("t1_vout2", Vout, 16'd2);
    chk("t1_tz_early", Tz, 1'b0);
    cyc();
    chk("t1_tz", Tz, 1'b1);
    chk("t1_busy_done", Busy, 1'b0);
    chk("t1_vout1", Vout, 16'd1);
    cyc();
    chk("t1_tz_pulse", Tz, 1'b0);
    chk("t1_vout0", Vout, 16'd0);

    // 2: auto-reload, load 4, continuous ticks
    Auto_reload = 1'b1;
    drv(1'b1, 16'd4, 1'b0, 1'b0, 1'b0); cyc();
    chk("t2_ack", Load_ack, 1'b1);
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b1); cyc();
    chk("t2_busy", Busy, 1'b1);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk($sformatf("t2_vout%0d", k), Vout, ar_vout[k]);
      chk($sformatf("t2_tz%0d", k), Tz, ar_tz[k]);
      chk($sformatf("t2_busy%0d", k), Busy, 1'b1);
    end
    Auto_reload = 1'b0;
    drv(1'b0, 16'd0, 1'b0, 1'b1, 1'b1); cyc();
    chk("t2_stop_busy", Busy, 1'b0);

    // 3: pause with a simultaneous Tick, then resume
    drv(1'b1, 16'd5, 1'b0, 1'b0, 1'b0); cyc();
    chk("t3_ack", Load_ack, 1'b1);
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t3_busy", Busy, 1'b1);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc(); cyc();
    drv(1'b0, 16'd0, 1'b0, 1'b1, 1'b1); cyc();
    chk("t3_stop_busy", Busy, 1'b0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc();
    chk("t3_hold3", Vout, 16'd3);
    cyc();
    chk("t3_hold3b", Vout, 16'd3);
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t3_resume", Busy, 1'b1);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc();
    chk("t3_tz_a", Tz, 1'b0);
    cyc();
    chk("t3_tz_b", Tz, 1'b0);
    cyc();
    chk("t3_tz", Tz, 1'b1);
    chk("t3_done", Busy, 1'b0);

    // 4: Load rejected in RUN; Load+Start in IDLE
    drv(1'b1, 16'd6, 1'b0, 1'b0, 1'b0); cyc();
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc();
    drv(1'b1, 16'd9, 1'b0, 1'b0, 1'b0); cyc();
    chk("t4_err", Load_err, 1'b1);
    chk("t4_no_ack", Load_ack, 1'b0);
    chk("t4_busy", Busy, 1'b1);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t4_err_pulse", Load_err, 1'b0);
    chk("t4_cnt_kept", Vout, 16'd5);
    drv(1'b0, 16'd0, 1'b0, 1'b1, 1'b0); cyc();
    drv(1'b1, 16'd2, 1'b1, 1'b0, 1'b0); cyc();
    chk("t4_ls_ack", Load_ack, 1'b1);
    chk("t4_ls_idle", Busy, 1'b0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t4_ls_vout", Vout, 16'd2);
    chk("t4_ls_still_idle", Busy, 1'b0);

    // 5: zero load expires on Start without Tick
    drv(1'b1, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t5_ack", Load_ack, 1'b1);
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t5_tz", Tz, 1'b1);
    chk("t5_busy", Busy, 1'b0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t5_tz_pulse", Tz, 1'b0);
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t5_tz_again", Tz, 1'b1);
    chk("t5_busy_again", Busy, 1'b0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t5_tz_pulse2", Tz, 1'b0);

    // 6a: async reset mid-RUN at cnt 7
    drv(1'b1, 16'd9, 1'b0, 1'b0, 1'b0); cyc();
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc(); cyc();
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t6_vout7", Vout, 16'd7);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6r_busy", Busy, 1'b0);
    chk("t6r_vout", Vout, 16'd0);
    chk("t6r_tz", Tz, 1'b0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc(); cyc();
    chk("t6r_tz_hold", Tz, 1'b0);
    Rst_n = 1'b1;
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t6r_nostart_busy", Busy, 1'b0);
    chk("t6r_nostart_tz", Tz, 1'b0);

    // 6b: Pwr_off mid-RUN at cnt 7
    drv(1'b1, 16'd10, 1'b0, 1'b0, 1'b0); cyc();
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc(); cyc(); cyc();
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t6p_vout7", Vout, 16'd7);
    #2 Pwr_off = 1'b1;
    #1;
    chk("t6p_busy", Busy, 1'b0);
    chk("t6p_vout", Vout, 16'd0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); cyc(); cyc();
    chk("t6p_tz_hold", Tz, 1'b0);
    Pwr_off = 1'b0;
    drv(1'b0, 16'd0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t6p_nostart_busy", Busy, 1'b0);
    chk("t6p_nostart_tz", Tz, 1'b0);
    drv(1'b0, 16'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t6p_nostart_vout", Vout, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
